// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain of DEPTH stages with bubble collapse and per-stage flush.
// Optional transfer statistics counter enabled by defining PIPE_CHAIN_STATS_EN.
module pipe_stage_chain #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_valid,
  input  logic [WIDTH-1:0]             i_data,
  output logic                         o_ready,
  input  logic [DEPTH-1:0]             i_flush,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_data,
  input  logic                         i_ready,
  output logic [DEPTH-1:0]             o_stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic [31:0]                  o_xfer_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] in_xfer;
  logic [DEPTH-1:0] out_xfer;
  logic             tail_full;
  logic [OCC_W-1:0] occ;

  // A stage is ready unless it and every stage after it are full with the sink stalled.
  always_comb begin
    tail_full  = 1'b1;
    rdy        = '0;
    rdy[DEPTH] = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tail_full = tail_full & valid[k];
      rdy[k]    = ~tail_full | i_ready;
    end
  end

  always_comb begin
    in_xfer    = '0;
    out_xfer   = '0;
    in_xfer[0] = i_valid & rdy[0];
    for (int k = 1; k < DEPTH; k++) begin
      in_xfer[k] = valid[k-1] & rdy[k];
    end
    for (int k = 0; k < DEPTH; k++) begin
      out_xfer[k] = valid[k] & rdy[k+1];
    end
  end

  // Flush overrides any arrival so an item moving into a flushed stage is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= RESET_VAL;
      end
    end else begin
      if (in_xfer[0]) begin
        data[0] <= i_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (in_xfer[k]) begin
          data[k] <= data[k-1];
        end
      end
      for (int k = 0; k < DEPTH; k++) begin
        valid[k] <= ~i_flush[k] & (in_xfer[k] | (valid[k] & ~out_xfer[k]));
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(valid[k]);
    end
  end

  assign o_ready       = rdy[0];
  assign o_valid       = valid[DEPTH-1];
  assign o_data        = data[DEPTH-1];
  assign o_stage_valid = valid;
  assign o_occupancy   = occ;

`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0] xfer_cnt;

  // Saturating so long runs never wrap back to a misleading small count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt <= '0;
    end else if (valid[DEPTH-1] && i_ready && (xfer_cnt != 32'hFFFF_FFFF)) begin
      xfer_cnt <= xfer_cnt + 32'd1;
    end
  end

  assign o_xfer_cnt = xfer_cnt;
`else
  assign o_xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus randomized traffic
// checked against a slot-occupancy model of the chain.
module tb_pipe_stage_chain;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [W-1:0]  i_data;
  logic          o_ready;
  logic [D-1:0]  i_flush;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic          i_ready;
  logic [D-1:0]  o_stage_valid;
  logic [2:0]    o_occupancy;
  logic [31:0]   o_xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Model: which slots hold an item and what it is; items move toward the output when the slot ahead frees.
  bit           mv [D];
  logic [W-1:0] md [D];
  bit           nv [D];
  logic [W-1:0] nd [D];
  bit           exp_ready;
  logic [31:0]  exp_cnt;
  logic [31:0]  next_cnt;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_stage_valid(o_stage_valid), .o_occupancy(o_occupancy), .o_xfer_cnt(o_xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] exp_sv();
    logic [D-1:0] s;
    for (int k = 0; k < D; k++) s[k] = mv[k];
    return s;
  endfunction

  function automatic int exp_occ();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(mv[k]);
    return n;
  endfunction

  function automatic logic [31:0] exp_xfer();
`ifdef PIPE_CHAIN_STATS_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) begin
      mv[k] = 1'b0; md[k] = '0; nv[k] = 1'b0; nd[k] = '0;
    end
    exp_cnt  = '0;
    next_cnt = '0;
  endtask

  // Drive inputs, then predict the next slot map by walking items from the output back to the input.
  task automatic present(input logic v, input logic [W-1:0] d, input logic r, input logic [D-1:0] f);
    i_valid = v; i_data = d; i_ready = r; i_flush = f;
    #1;
    for (int k = 0; k < D; k++) begin
      nv[k] = 1'b0; nd[k] = md[k];
    end
    next_cnt = exp_cnt;
    for (int k = D - 1; k >= 0; k--) begin
      if (mv[k]) begin
        if (k == D - 1) begin
          if (r) begin
            if (next_cnt != 32'hFFFF_FFFF) next_cnt = next_cnt + 32'd1;
          end else begin
            nv[k] = 1'b1;
          end
        end else if (!nv[k+1]) begin
          nv[k+1] = 1'b1; nd[k+1] = md[k];
        end else begin
          nv[k] = 1'b1;
        end
      end
    end
    exp_ready = !nv[0];
    if (v && exp_ready) begin
      nv[0] = 1'b1; nd[0] = d;
    end
    for (int k = 0; k < D; k++) if (f[k]) nv[k] = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    mv = nv; md = nd; exp_cnt = next_cnt;
    @(negedge clk);
  endtask

  task automatic clear_chain();
    present(1'b0, '0, 1'b0, '1);
    advance();
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_flush = '0;
    model_reset();
    #3;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_occupancy !== 3'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d want 0", o_occupancy); end
    checks++; if (o_stage_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_sv got %b want 0000", o_stage_valid); end
    checks++; if (o_xfer_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", o_xfer_cnt); end
    checks++; if (o_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", o_data); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 10; i++) begin
      present(1'b1, W'(i), 1'b1, '0);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready cyc %0d got %b want 1", i, o_ready); end
      checks++; if (o_valid !== (i >= 5)) begin errors++; $display("[TB] FAIL stream_valid cyc %0d got %b want %b", i, o_valid, (i >= 5)); end
      if (i >= 5) begin
        checks++; if (o_data !== W'(i - 4)) begin errors++; $display("[TB] FAIL stream_data cyc %0d got %0d want %0d", i, o_data, i - 4); end
      end
      advance();
    end
    clear_chain();
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 5; i++) begin
      present(1'b1, W'(i), 1'b0, '0);
      checks++; if (o_ready !== (i <= 4)) begin errors++; $display("[TB] FAIL bp_ready item %0d got %b want %b", i, o_ready, (i <= 4)); end
      if (i == 5) begin
        checks++; if (o_occupancy !== 3'd4) begin errors++; $display("[TB] FAIL bp_occ got %0d want 4", o_occupancy); end
      end else begin
        advance();
      end
    end
    present(1'b1, W'(5), 1'b1, '0);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 1", o_ready); end
    checks++; if (o_data !== 32'd1) begin errors++; $display("[TB] FAIL bp_release_data got %0d want 1", o_data); end
    advance();
    for (int c = 0; c < 6; c++) begin
      present(1'b0, '0, 1'b1, '0);
      checks++; if (o_valid !== mv[D-1]) begin errors++; $display("[TB] FAIL bp_drain_valid got %b want %b", o_valid, mv[D-1]); end
      if (mv[D-1]) begin
        checks++; if (o_data !== md[D-1]) begin errors++; $display("[TB] FAIL bp_drain_data got %0d want %0d", o_data, md[D-1]); end
      end
      advance();
    end
  endtask

  task automatic test_bubble();
    present(1'b1, 32'hA, 1'b0, '0); advance();
    present(1'b0, '0, 1'b0, '0); advance();
    present(1'b0, '0, 1'b0, '0); advance();
    present(1'b1, 32'hB, 1'b0, '0); advance();
    for (int c = 0; c < 4; c++) begin
      present(1'b0, '0, 1'b0, '0); advance();
    end
    present(1'b0, '0, 1'b0, '0);
    checks++; if (o_stage_valid !== 4'b1100) begin errors++; $display("[TB] FAIL bubble_sv got %b want 1100", o_stage_valid); end
    checks++; if (o_data !== 32'hA) begin errors++; $display("[TB] FAIL bubble_data got %h want a", o_data); end
    advance();
    clear_chain();
  endtask

  task automatic test_flush();
    logic [W-1:0] want [3];
    int got_n = 0;
    want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd4;
    for (int i = 1; i <= 4; i++) begin
      present(1'b1, W'(i), 1'b0, '0); advance();
    end
    present(1'b0, '0, 1'b0, 4'b0010);
    checks++; if (o_stage_valid !== 4'b1111) begin errors++; $display("[TB] FAIL flush_full_sv got %b want 1111", o_stage_valid); end
    advance();
    for (int c = 0; c < 6; c++) begin
      present(1'b0, '0, 1'b1, '0);
      if (c == 0) begin
        checks++; if (o_stage_valid !== 4'b1101) begin errors++; $display("[TB] FAIL flush_sv got %b want 1101", o_stage_valid); end
      end
      if (o_valid) begin
        checks++;
        if (got_n >= 3) begin errors++; $display("[TB] FAIL flush_extra got %0d want none", o_data); end
        else if (o_data !== want[got_n]) begin errors++; $display("[TB] FAIL flush_seq idx %0d got %0d want %0d", got_n, o_data, want[got_n]); end
        got_n++;
      end
      advance();
    end
    checks++; if (got_n != 3) begin errors++; $display("[TB] FAIL flush_count got %0d want 3", got_n); end
  endtask

  task automatic test_flush_arrival();
    present(1'b1, 32'h55, 1'b0, '0); advance();
    present(1'b0, '0, 1'b0, 4'b0010);
    checks++; if (o_occupancy !== 3'd1) begin errors++; $display("[TB] FAIL fa_occ_before got %0d want 1", o_occupancy); end
    advance();
    present(1'b0, '0, 1'b0, '0);
    checks++; if (o_occupancy !== 3'd0) begin errors++; $display("[TB] FAIL fa_occ_after got %0d want 0", o_occupancy); end
    checks++; if (o_stage_valid !== 4'b0000) begin errors++; $display("[TB] FAIL fa_sv got %b want 0000", o_stage_valid); end
    advance();
  endtask

  task automatic test_async_reset();
    int lat = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      present(1'b1, W'(100 + i), 1'b1, '0); advance();
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid got %b want 0", o_valid); end
    checks++; if (o_occupancy !== 3'd0) begin errors++; $display("[TB] FAIL ar_occ got %0d want 0", o_occupancy); end
    checks++; if (o_xfer_cnt !== 32'd0) begin errors++; $display("[TB] FAIL ar_cnt got %0d want 0", o_xfer_cnt); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    present(1'b1, 32'hAB, 1'b1, '0); advance();
    while (!seen && lat < 10) begin
      present(1'b0, '0, 1'b1, '0);
      lat++;
      if (o_valid) begin
        seen = 1'b1;
        checks++; if (o_data !== 32'hAB) begin errors++; $display("[TB] FAIL ar_data got %h want ab", o_data); end
      end
      advance();
    end
    checks++; if (!seen || lat != 4) begin errors++; $display("[TB] FAIL ar_latency got %0d (seen %b) want 4", lat, seen); end
  endtask

  task automatic test_random();
    logic          v;
    logic          r;
    logic [D-1:0]  f;
    for (int c = 0; c < 500; c++) begin
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0) ? D'($urandom_range(0, 15)) : '0;
      present(v, $urandom, r, f);
      checks++; if (o_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", c, o_ready, exp_ready); end
      checks++; if (o_valid !== mv[D-1]) begin errors++; $display("[TB] FAIL rnd_valid cyc %0d got %b want %b", c, o_valid, mv[D-1]); end
      if (mv[D-1]) begin
        checks++; if (o_data !== md[D-1]) begin errors++; $display("[TB] FAIL rnd_data cyc %0d got %h want %h", c, o_data, md[D-1]); end
      end
      checks++; if (o_stage_valid !== exp_sv()) begin errors++; $display("[TB] FAIL rnd_sv cyc %0d got %b want %b", c, o_stage_valid, exp_sv()); end
      checks++; if (o_occupancy !== 3'(exp_occ())) begin errors++; $display("[TB] FAIL rnd_occ cyc %0d got %0d want %0d", c, o_occupancy, exp_occ()); end
      checks++; if (o_xfer_cnt !== exp_xfer()) begin errors++; $display("[TB] FAIL rnd_cnt cyc %0d got %0d want %0d", c, o_xfer_cnt, exp_xfer()); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_flush_arrival();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
